// File: rtl/mvu_serial_pkg.sv
// Shared types and helpers for the bit-serial datapath receivers.
// Holds the counter-width helper and the holding-register state enum.
package mvu_serial_pkg;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

endpackage

// File: rtl/shiftreg_deser_hold.sv
// Single-entry valid/ready holding register with sticky overflow.
// A word offered while full and not draining is dropped.
module shiftreg_deser_hold
  import mvu_serial_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         overflow
);

  hold_state_t  state_q, state_d;
  logic [W-1:0] data_q, data_d;
  logic         ovf_q, ovf_d;
  logic         pop;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    pop     = (state_q == HOLD_FULL) && out_ready;
    if (clr) begin
      state_d = HOLD_EMPTY;
      data_d  = '0;
      ovf_d   = 1'b0;
    end else if (in_valid) begin
      if ((state_q == HOLD_EMPTY) || pop) begin
        state_d = HOLD_FULL;
        data_d  = in_data;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (pop) begin
      state_d = HOLD_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HOLD_EMPTY;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = (state_q == HOLD_FULL);
  assign overflow  = ovf_q;

endmodule

// File: rtl/shiftreg_deser.sv
// Bit-serial to parallel deserializer, MSB first by default.
// Define SHIFTREG_DESER_LSB_FIRST_EN for LSB-first assembly.
module shiftreg_deser
  import mvu_serial_pkg::*;
#(
  parameter  int W  = 8,
  localparam int CW = cnt_width(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          step,
  input  logic          in,
  input  logic          sync,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] bit_cnt,
  output logic          overflow
);

  logic [W-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  shifted;
  logic [W-1:0]  first;
  logic          cpl;

`ifdef SHIFTREG_DESER_LSB_FIRST_EN
  assign shifted = {in, sr_q[W-1:1]};
  assign first   = {in, {(W-1){1'b0}}};
`else
  assign shifted = {sr_q[W-2:0], in};
  assign first   = {{(W-1){1'b0}}, in};
`endif

  // sync restarts the word; it never completes one
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    cpl   = 1'b0;
    if (clr) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (step) begin
      if (sync) begin
        sr_d  = first;
        cnt_d = CW'(1);
      end else begin
        sr_d = shifted;
        if (cnt_q == CW'(W - 1)) begin
          cpl   = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign bit_cnt = cnt_q;

  shiftreg_deser_hold #(
    .W(W)
  ) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (cpl),
    .in_data  (shifted),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_shiftreg_deser.sv
// Bench for shiftreg_deser: behavioural model plus directed literals.
module tb_shiftreg_deser;

  localparam int W  = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          step = 1'b0;
  logic          in_b = 1'b0;
  logic          sync = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic [CW-1:0] bit_cnt;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  shiftreg_deser #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .step     (step),
    .in       (in_b),
    .sync     (sync),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .bit_cnt  (bit_cnt),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Model: partial word as an integer plus a bit count
  longint unsigned acc;
  int              n;
  logic [W-1:0]    m_data;
  bit              m_valid;
  bit              m_ovf;

  always @(posedge clk or negedge rst_n) begin
    bit           pop;
    bit           done;
    logic [W-1:0] word;
    if (!rst_n || clr) begin
      acc = 0; n = 0;
      m_data = '0; m_valid = 0; m_ovf = 0;
    end else begin
      pop  = m_valid && out_ready;
      done = 0;
      word = '0;
      if (step) begin
        if (sync) begin
          acc = in_b;
          n   = 1;
        end else begin
`ifdef SHIFTREG_DESER_LSB_FIRST_EN
          acc = acc + (longint'(in_b) << n);
`else
          acc = acc * 2 + in_b;
`endif
          n = n + 1;
          if (n == W) begin
            done = 1;
            word = acc[W-1:0];
            acc  = 0;
            n    = 0;
          end
        end
      end
      if (done) begin
        if (!m_valid || pop) begin
          m_valid = 1;
          m_data  = word;
        end else begin
          m_ovf = 1;
        end
      end else if (pop) begin
        m_valid = 0;
      end
    end
  end

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_data", out_data, m_data);
      chk("m_valid", out_valid, m_valid);
      chk("m_cnt", bit_cnt, n);
      chk("m_ovf", overflow, m_ovf);
    end
  end

  task automatic cyc(input bit s, input bit b,
                     input bit y, input bit r);
    @(negedge clk);
    step = s; in_b = b; sync = y;
    out_ready = r; clr = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    step = 0; sync = 0; clr = 1'b1;
  endtask

  task automatic send_word(input logic [W-1:0] w,
                           input bit r);
    for (int i = 0; i < W; i++) begin
`ifdef SHIFTREG_DESER_LSB_FIRST_EN
      cyc(1, w[i], 0, r);
`else
      cyc(1, w[W-1-i], 0, r);
`endif
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] sync_exp;
  logic [W-1:0] pat_exp;

  initial begin
    bit [7:0] pat;
`ifdef SHIFTREG_DESER_LSB_FIRST_EN
    sync_exp = 8'h01;
    pat_exp  = 8'h05;
`else
    sync_exp = 8'h80;
    pat_exp  = 8'hA0;
`endif
    #12;
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_cnt", bit_cnt, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // A5 with out_ready low
    pat = 8'b1010_0101;
    for (int i = 0; i < 8; i++) cyc(1, pat[7-i], 0, 0);
    after_edge();
    chk("a5_valid", out_valid, 1);
    chk("a5_data", out_data, 8'hA5);
    chk("a5_cnt", bit_cnt, 0);
    chk("a5_ovf", overflow, 0);

    // back-to-back with out_ready high
    do_clr();
    send_word(8'h3C, 1);
    after_edge();
    chk("b2b_first", out_data, 8'h3C);
    send_word(8'hC3, 1);
    after_edge();
    chk("b2b_second", out_data, 8'hC3);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_ovf", overflow, 0);

    // overflow with out_ready low
    do_clr();
    send_word(8'h11, 0);
    send_word(8'h22, 0);
    after_edge();
    chk("ovf_data", out_data, 8'h11);
    chk("ovf_set", overflow, 1);
    cyc(0, 0, 0, 1);
    after_edge();
    chk("ovf_pop_valid", out_valid, 0);
    chk("ovf_sticky", overflow, 1);
    cyc(0, 0, 0, 0);

    // sync restart
    do_clr();
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 0);
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0);
    after_edge();
    chk("sync_data", out_data, sync_exp);
    chk("sync_valid", out_valid, 1);

    // partial word killed by clr
    do_clr();
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    do_clr();
    for (int i = 0; i < 7; i++) cyc(1, 1, 0, 0);
    after_edge();
    chk("clr_7th_valid", out_valid, 0);
    cyc(1, 1, 0, 0);
    after_edge();
    chk("clr_ff", out_data, 8'hFF);
    chk("clr_cnt", bit_cnt, 0);

    // asynchronous reset mid-cycle
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
    after_edge();
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_data", out_data, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_cnt", bit_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    do_clr();
    send_word(8'hFF, 0);
    after_edge();
    chk("arst_ff", out_data, 8'hFF);

    // bit-order pattern 1,0,1,0,0,0,0,0
    do_clr();
    pat = 8'b1010_0000;
    for (int i = 0; i < 8; i++) cyc(1, pat[7-i], 0, 0);
    after_edge();
    chk("order_data", out_data, pat_exp);

    // randomized traffic
    do_clr();
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) < 7,
          1'($urandom_range(0, 1)),
          $urandom_range(0, 39) == 0,
          1'($urandom_range(0, 1)));
      if ($urandom_range(0, 199) == 0) clr = 1'b1;
    end
    cyc(0, 0, 0, 0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
